// File: rtl/ram_access_ctrl.sv
// Byte-addressed host port in front of a word-wide RAM.
// Partial stores become read-modify-write; out-of-range indices get an error response.
module ram_access_ctrl #(
  parameter int unsigned DEPTH = 32'd16777216
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        ram_cen,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  localparam logic [32:0] DEPTH_W = 33'(DEPTH);

  state_t      state;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [29:0] idx;
  logic        oob;
  logic        is_err;
  logic        is_ld;
  logic        is_full;
  logic        is_nop;
  logic        unused_addr_lsb;

  assign idx = req_addr[31:2];
  assign unused_addr_lsb = ^req_addr[1:0];

  // Full 30-bit index compare, widened so DEPTH >= 2^30 still works.
  assign oob     = {3'b000, idx} >= DEPTH_W;
  assign is_err  = oob;
  assign is_ld   = !oob && !req_we;
  assign is_full = !oob && req_we && (req_be == 4'hF);
  assign is_nop  = !oob && req_we && (req_be == 4'h0);

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      ram_cen    <= 1'b0;
      ram_wen    <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            wdata_q   <= req_wdata;
            be_q      <= req_be;
            ram_addr  <= {2'b00, idx};
            req_ready <= 1'b0;
            unique case (1'b1)
              is_err: begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_err   <= 1'b1;
                resp_rdata <= '0;
              end
              is_ld: begin
                state   <= RD;
                ram_cen <= 1'b1;
                ram_wen <= 1'b0;
              end
              is_full: begin
                state   <= WR;
                ram_cen <= 1'b1;
                ram_wen <= 1'b1;
                ram_din <= req_wdata;
              end
              is_nop: begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_err   <= 1'b0;
                resp_rdata <= '0;
              end
              default: begin
                state   <= RD;
                ram_cen <= 1'b1;
                ram_wen <= 1'b0;
              end
            endcase
          end
        end
        RD: begin
          if (!we_q) begin
            state      <= RESP;
            ram_cen    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= ram_dout;
          end else begin
            // Old word is merged here so WR only has to drive it.
            state   <= WR;
            ram_wen <= 1'b1;
            ram_din <= merge(ram_dout, wdata_q, be_q);
          end
        end
        WR: begin
          state      <= RESP;
          ram_cen    <= 1'b0;
          ram_wen    <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: word-array RAM, latency-table model
// with a per-cycle compare, plus literal checks on known vectors.
module tb_ram_access_ctrl;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        ram_cen;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  ram_access_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata),
    .ram_cen(ram_cen), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH] = '{default: '0};
  logic        in_rng;
  assign in_rng = ram_addr < 32'(DEPTH);
  assign ram_dout = (ram_cen && !ram_wen && in_rng) ? mem[ram_addr[7:0]] : '0;
  always @(posedge clk)
    if (ram_cen && ram_wen && in_rng) mem[ram_addr[7:0]] <= ram_din;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int busy_end = -1;
  int acc_cyc = 0;
  int acc_cnt = 0;
  logic [31:0] ref_mem [DEPTH] = '{default: '0};
  bit          e_rv [int];
  bit          e_err [int];
  logic [31:0] e_rd [int];
  bit          e_cen [int];
  bit          e_wen [int];
  logic [31:0] e_addr [int];
  logic [31:0] e_din [int];
  int          w_idx [int];
  logic [31:0] w_val [int];
  logic [31:0] last_rdata;
  bit          last_err;
  int          last_lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] vec(input int i);
    return (32'h9E3779B9 * 32'(i + 1)) ^ 32'(i);
  endfunction

  // Model: on each accept, lay out the RAM and response activity by cycle.
  always @(posedge clk) begin
    logic [29:0] ix;
    logic [31:0] m;
    int k;
    cyc++;
    k = cyc;
    if (rst) begin
      e_rv.delete(); e_err.delete(); e_rd.delete();
      e_cen.delete(); e_wen.delete(); e_addr.delete(); e_din.delete();
      w_idx.delete(); w_val.delete();
      busy_end = -1;
    end else begin
      if (w_val.exists(k)) ref_mem[w_idx[k]] = w_val[k];
      if (req_valid && req_ready) begin
        acc_cnt++;
        acc_cyc = k;
        ix = req_addr[31:2];
        if (ix >= 30'(DEPTH)) begin
          e_rv[k] = 1; e_err[k] = 1; e_rd[k] = 0; busy_end = k;
        end else if (!req_we) begin
          e_cen[k] = 1; e_wen[k] = 0; e_addr[k] = 32'(ix);
          e_rv[k+1] = 1; e_err[k+1] = 0; e_rd[k+1] = ref_mem[ix[7:0]];
          busy_end = k + 1;
        end else if (req_be == 4'hF) begin
          e_cen[k] = 1; e_wen[k] = 1; e_addr[k] = 32'(ix); e_din[k] = req_wdata;
          w_idx[k+1] = int'(ix); w_val[k+1] = req_wdata;
          e_rv[k+1] = 1; e_err[k+1] = 0; e_rd[k+1] = 0;
          busy_end = k + 1;
        end else if (req_be == 4'h0) begin
          e_rv[k] = 1; e_err[k] = 0; e_rd[k] = 0; busy_end = k;
        end else begin
          m = merge_bytes(ref_mem[ix[7:0]], req_wdata, req_be);
          e_cen[k] = 1; e_wen[k] = 0; e_addr[k] = 32'(ix);
          e_cen[k+1] = 1; e_wen[k+1] = 1; e_addr[k+1] = 32'(ix); e_din[k+1] = m;
          w_idx[k+2] = int'(ix); w_val[k+2] = m;
          e_rv[k+2] = 1; e_err[k+2] = 0; e_rd[k+2] = 0;
          busy_end = k + 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit rv;
    bit cen;
    if (rst) begin
      chk("rst_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_cen", ram_cen, 0);
      chk("rst_wen", ram_wen, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_din", ram_din, 0);
    end else begin
      rv = e_rv.exists(cyc);
      cen = e_cen.exists(cyc);
      chk("req_ready", req_ready, 32'(cyc > busy_end));
      chk("resp_valid", resp_valid, 32'(rv));
      if (rv) begin
        chk("resp_err", resp_err, 32'(e_err[cyc]));
        chk("resp_rdata", resp_rdata, e_rd[cyc]);
      end
      chk("ram_cen", ram_cen, 32'(cen));
      if (cen) begin
        chk("ram_wen", ram_wen, 32'(e_wen[cyc]));
        chk("ram_addr", ram_addr, e_addr[cyc]);
        if (e_wen[cyc]) chk("ram_din", ram_din, e_din[cyc]);
      end
      if (resp_valid) begin
        last_rdata = resp_rdata;
        last_err = resp_err;
        last_lat = cyc - acc_cyc + 1;
      end
    end
  end

  task automatic wait_acc();
    int n0;
    bit ok;
    n0 = acc_cnt;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != n0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: no accept within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (cyc <= busy_end && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (cyc <= busy_end) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: still busy at cycle %0d", cyc);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    last_lat = -1;
    last_rdata = 32'hA5A5A5A5;
    last_err = 1'b1;
    req_we = we; req_addr = a; req_wdata = d; req_be = be;
    req_valid = 1'b1;
    wait_acc();
    req_valid = 1'b0;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    do_req(0, 32'h0, 32'h0, 4'h0);
    chk("idle_rd0_data", last_rdata, 32'h0);
    chk("idle_rd0_err", 32'(last_err), 0);
    chk("idle_rd0_lat", last_lat, 2);

    do_req(1, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("full_st_lat", last_lat, 2);
    chk("full_st_mem", mem[4], 32'hDEADBEEF);
    do_req(0, 32'h10, 32'h0, 4'h0);
    chk("full_ld_data", last_rdata, 32'hDEADBEEF);
    chk("full_ld_lat", last_lat, 2);

    do_req(1, 32'h12, 32'h11223344, 4'b0101);
    chk("rmw_lat", last_lat, 3);
    chk("rmw_mem", mem[4], 32'hDE22BE44);
    do_req(0, 32'h10, 32'h0, 4'h0);
    chk("rmw_ld_data", last_rdata, 32'hDE22BE44);

    do_req(1, 32'h20, 32'hFFFFFFFF, 4'h0);
    chk("be0_lat", last_lat, 1);
    chk("be0_err", 32'(last_err), 0);
    chk("be0_mem", mem[8], 32'h0);

    do_req(0, 32'h400, 32'h0, 4'h0);
    chk("oob_err", 32'(last_err), 1);
    chk("oob_data", last_rdata, 32'h0);
    chk("oob_lat", last_lat, 1);
    do_req(0, 32'h3FC, 32'h0, 4'h0);
    chk("last_word_err", 32'(last_err), 0);
    chk("last_word_lat", last_lat, 2);
    do_req(0, 32'hFFFFFFFC, 32'h0, 4'h0);
    chk("oob_hi_err", 32'(last_err), 1);
    do_req(1, 32'h40000400, 32'h12345678, 4'hF);
    chk("oob_trunc_err", 32'(last_err), 1);
    chk("oob_trunc_mem0", mem[0], 32'h0);

    // req_valid stays high across all 128 requests; each vector is
    // swapped in right after its accept edge.
    n0 = acc_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    for (int i = 0; i < 128; i++) begin
      req_we = (i < 64);
      req_addr = 32'((64 + (i % 64)) * 4);
      req_wdata = vec(i % 64);
      req_be = 4'hF;
      wait_acc();
    end
    req_valid = 1'b0;
    drain();
    chk("b2b_accepts", 32'(acc_cnt - n0), 128);
    chk("b2b_mem64", mem[64], 32'h9E3779B9);
    chk("b2b_mem101", mem[101], vec(37));

    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'b0011;
    req_valid = 1'b1;
    wait_acc();
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wr_cycle_wen", ram_wen, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_cen", ram_cen, 0);
    chk("rst_async_valid", resp_valid, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    chk("rst_wr_mem8", mem[8], 32'h0);
    do_req(0, 32'h20, 32'h0, 4'h0);
    chk("rst_wr_ld_data", last_rdata, 32'h0);
    chk("rst_wr_ld_err", 32'(last_err), 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
